// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes a WS2812 single-wire stream into 24-bit pixels,
// reporting end of frame at the latch gap and flagging malformed pulses.
// Ports:
//   clk          system clock
//   rst          synchronous reset, active low
//   din          WS2812 serial line (asynchronous)
//   pixel_data   decoded pixel, wire order G/R/B, MSB first
//   pixel_valid  1-cycle strobe for pixel_data/pixel_index
//   pixel_index  0-based pixel position in frame (saturating)
//   frame_done   1-cycle strobe at latch gap ending a non-empty frame
//   frame_pixels pixel count of last finished frame
//   bit_error    1-cycle strobe on malformed pulse or truncated pixel
module ws2812_rx #(
    parameter int THRESH_CYCLES = 29,
    parameter int MIN_HIGH      = 8,
    parameter int MAX_HIGH      = 60,
    parameter int RESET_CYCLES  = 2400,
    parameter int IDX_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [23:0]      pixel_data,
    output logic             pixel_valid,
    output logic [IDX_W-1:0] pixel_index,
    output logic             frame_done,
    output logic [IDX_W-1:0] frame_pixels,
    output logic             bit_error
);

    localparam int LW = $clog2(RESET_CYCLES + 1);
    localparam int HW = $clog2(MAX_HIGH + 2);

    localparam logic [LW-1:0]    GAP  = LW'(RESET_CYCLES);
    localparam logic [HW-1:0]    HSAT = HW'(MAX_HIGH + 1);
    localparam logic [HW-1:0]    HMAX = HW'(MAX_HIGH);
    localparam logic [HW-1:0]    HMIN = HW'(MIN_HIGH);
    localparam logic [HW-1:0]    HTHR = HW'(THRESH_CYCLES);
    localparam logic [IDX_W-1:0] PSAT = '1;

    typedef enum logic [1:0] {
        WAIT_GAP,
        IDLE,
        HIGH,
        LOW
    } state_e;

    state_e           state_q;
    logic             s1_q;
    logic             s2_q;
    logic             prev_q;
    logic [LW-1:0]    low_cnt_q;
    logic [HW-1:0]    high_cnt_q;
    logic [4:0]       bit_cnt_q;
    logic [IDX_W-1:0] pix_cnt_q;
    logic [23:0]      shift_q;
    logic             emit_q;

    logic rise;
    logic fall;

    assign rise = s2_q & ~prev_q;
    assign fall = ~s2_q & prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= din;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= WAIT_GAP;
            low_cnt_q    <= '0;
            high_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            shift_q      <= '0;
            emit_q       <= 1'b0;
            pixel_data   <= '0;
            pixel_valid  <= 1'b0;
            pixel_index  <= '0;
            frame_done   <= 1'b0;
            frame_pixels <= '0;
            bit_error    <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            bit_error   <= 1'b0;
            emit_q      <= 1'b0;

            unique case (state_q)
                WAIT_GAP: begin
                    if (s2_q) begin
                        low_cnt_q <= '0;
                    end else if (low_cnt_q == GAP) begin
                        state_q <= IDLE;
                    end else begin
                        low_cnt_q <= low_cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (rise) begin
                        state_q    <= HIGH;
                        high_cnt_q <= HW'(1);
                    end
                end
                HIGH: begin
                    // Over-long check first: a pulse ending exactly one
                    // cycle past MAX_HIGH is still a stuck line.
                    if (high_cnt_q > HMAX || (fall && high_cnt_q < HMIN)) begin
                        bit_error <= 1'b1;
                        state_q   <= WAIT_GAP;
                        low_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        pix_cnt_q <= '0;
                    end else if (fall) begin
                        shift_q   <= {shift_q[22:0], (high_cnt_q >= HTHR)};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        emit_q    <= (bit_cnt_q == 5'd23);
                        state_q   <= LOW;
                        low_cnt_q <= LW'(1);
                    end else if (high_cnt_q != HSAT) begin
                        high_cnt_q <= high_cnt_q + 1'b1;
                    end
                end
                LOW: begin
                    if (low_cnt_q == GAP) begin
                        if (bit_cnt_q != '0) begin
                            bit_error <= 1'b1;
                        end else if (pix_cnt_q != '0) begin
                            frame_done   <= 1'b1;
                            frame_pixels <= pix_cnt_q;
                        end
                        bit_cnt_q <= '0;
                        pix_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else if (rise) begin
                        state_q    <= HIGH;
                        high_cnt_q <= HW'(1);
                    end else begin
                        low_cnt_q <= low_cnt_q + 1'b1;
                    end
                end
            endcase

            // Pixel goes out the cycle after the 24th bit is shifted in.
            if (emit_q && state_q == LOW) begin
                pixel_valid <= 1'b1;
                pixel_data  <= shift_q;
                pixel_index <= pix_cnt_q;
                bit_cnt_q   <= '0;
                if (pix_cnt_q != PSAT) begin
                    pix_cnt_q <= pix_cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed self-checking bench for ws2812_rx.
// Drives hand-built WS2812 waveforms and checks decoded pixels/strobes.
module tb_ws2812_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        din = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [7:0]  pixel_index;
    logic        frame_done;
    logic [7:0]  frame_pixels;
    logic        bit_error;

    logic [23:0] s_data;
    logic        s_valid;
    logic [1:0]  s_index;
    logic        s_done;
    logic [1:0]  s_pixels;
    logic        s_err;

    ws2812_rx u_dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .pixel_index  (pixel_index),
        .frame_done   (frame_done),
        .frame_pixels (frame_pixels),
        .bit_error    (bit_error)
    );

    ws2812_rx #(.IDX_W(2)) u_sat (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .pixel_data   (s_data),
        .pixel_valid  (s_valid),
        .pixel_index  (s_index),
        .frame_done   (s_done),
        .frame_pixels (s_pixels),
        .bit_error    (s_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int pv_cyc = 0;
    int fd_cyc = 0;
    int fd_n = 0;
    int fd_pix = 0;
    int be_n = 0;
    int s_idx = 0;
    int s_fp = 0;
    logic [23:0] pv_q[$];
    logic [7:0]  idx_q[$];
    logic [23:0] exp_px[5];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pixel_valid) begin
            pv_q.push_back(pixel_data);
            idx_q.push_back(pixel_index);
            pv_cyc = cyc;
        end
        if (frame_done) begin
            fd_n++;
            fd_pix = int'(frame_pixels);
            fd_cyc = cyc;
        end
        if (bit_error) be_n++;
        if (s_valid) s_idx = int'(s_index);
        if (s_done) s_fp = int'(s_pixels);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        pv_q.delete();
        idx_q.delete();
        fd_n = 0;
        be_n = 0;
    endtask

    task automatic bitw(input int hi, input int lo);
        din = 1'b1;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        fall_cyc = cyc;
        repeat (lo) @(negedge clk);
    endtask

    task automatic pix(input logic [23:0] p);
        for (int i = 23; i >= 0; i--) begin
            if (p[i]) bitw(38, 22);
            else bitw(19, 41);
        end
    endtask

    task automatic gap(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_one(input string tag, input logic [23:0] px);
        chk({tag, "_pv_n"}, pv_q.size(), 1);
        if (pv_q.size() > 0) begin
            chk({tag, "_data"}, pv_q[0], px);
            chk({tag, "_idx"}, idx_q[0], 0);
        end
        chk({tag, "_fd_n"}, fd_n, 1);
        chk({tag, "_fp"}, fd_pix, 1);
    endtask

    initial begin
        exp_px[0] = 24'h123456;
        exp_px[1] = 24'hFF0080;
        exp_px[2] = 24'h00FF01;
        exp_px[3] = 24'hC3C3C3;
        exp_px[4] = 24'h7E0001;

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", pixel_data, 0);
        chk("rst_pv", pixel_valid, 0);
        chk("rst_idx", pixel_index, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_fp", frame_pixels, 0);
        chk("rst_be", bit_error, 0);
        rst = 1'b1;

        // 1: single pixel, latency of pixel_valid and frame_done
        clr();
        gap(2410);
        pix(24'hA53CF0);
        chk("t1_pv_lat", pv_cyc - fall_cyc, 4);
        gap(2450);
        chk_one("t1", 24'hA53CF0);
        chk("t1_fd_lat", fd_cyc - fall_cyc, 2403);
        chk("t1_be", be_n, 0);

        // 2: five pixels, index order and 2-bit index saturation
        clr();
        for (int k = 0; k < 5; k++) pix(exp_px[k]);
        gap(2450);
        chk("t2_pv_n", pv_q.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < pv_q.size()) begin
                chk($sformatf("t2_data%0d", k), pv_q[k], exp_px[k]);
                chk($sformatf("t2_idx%0d", k), idx_q[k], k);
            end
        end
        chk("t2_fd_n", fd_n, 1);
        chk("t2_fp", fd_pix, 5);
        chk("t2_be", be_n, 0);
        chk("t2_sat_idx", s_idx, 3);
        chk("t2_sat_fp", s_fp, 3);

        // 3: threshold 28/29, MIN_HIGH 8 ok, 7 is a glitch
        clr();
        for (int i = 0; i < 8; i++) bitw(28, 30);
        for (int i = 0; i < 8; i++) bitw(29, 30);
        for (int i = 0; i < 8; i++) bitw(8, 30);
        chk("t3_pv_n", pv_q.size(), 1);
        if (pv_q.size() > 0) chk("t3_data", pv_q[0], 24'h00FF00);
        chk("t3_be0", be_n, 0);
        bitw(7, 30);
        chk("t3_be1", be_n, 1);
        pix(24'hFFFFFF);
        gap(2450);
        chk("t3_pv_blk", pv_q.size(), 1);
        chk("t3_fd_blk", fd_n, 0);
        clr();
        pix(24'h0F0F0F);
        gap(2450);
        chk_one("t3r", 24'h0F0F0F);
        chk("t3r_be", be_n, 0);

        // 4: 60 high is legal, 61 high is a stuck line
        clr();
        for (int i = 0; i < 24; i++) bitw(60, 30);
        chk("t4_60_pv", pv_q.size(), 1);
        if (pv_q.size() > 0) chk("t4_60_data", pv_q[0], 24'hFFFFFF);
        gap(2450);
        clr();
        bitw(61, 2450);
        chk("t4_be", be_n, 1);
        pix(24'h00AA55);
        gap(2450);
        chk_one("t4", 24'h00AA55);
        chk("t4_be_after", be_n, 1);

        // 5: truncated pixel at latch gap
        clr();
        for (int i = 0; i < 12; i++) bitw(38, 22);
        gap(2450);
        chk("t5_be", be_n, 1);
        chk("t5_pv_n", pv_q.size(), 0);
        chk("t5_fd_n", fd_n, 0);
        clr();
        pix(24'h5A5A5A);
        gap(2450);
        chk_one("t5r", 24'h5A5A5A);

        // 6: reset in the middle of a pixel
        clr();
        for (int i = 0; i < 10; i++) bitw(38, 22);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("t6_data", pixel_data, 0);
        chk("t6_idx", pixel_index, 0);
        chk("t6_fp", frame_pixels, 0);
        chk("t6_strb", {pixel_valid, frame_done, bit_error}, 0);
        for (int i = 0; i < 14; i++) bitw(38, 22);
        gap(2450);
        chk("t6_pv_n", pv_q.size(), 0);
        chk("t6_fd_n", fd_n, 0);
        chk("t6_be", be_n, 0);
        pix(24'h3C00C3);
        gap(2450);
        chk_one("t6r", 24'h3C00C3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
